tmds_video_encoder: RTL and testbench

//  Consumes the registered 24-bit RGB + DE/HSYNC/VSYNC stream from the video pattern/diagram generator.

---
 rtl/tmds_pkg.sv | 36 +++
 rtl/tmds_channel_encoder.sv | 105 ++++++++++
 rtl/tmds_video_encoder.sv | 78 +++++++
 tb/tb_tmds_video_encoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared types, control tokens and helpers for the TMDS video encoder.
package tmds_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SYM_W  = 10;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned N1_W   = 4;
    localparam int unsigned RGB_W  = 24;

    typedef logic [SYM_W-1:0]        tmds_symbol_t;
    typedef logic signed [CNT_W-1:0] tmds_disparity_t;

    // One pixel-clock worth of generator input after the optional sync inversion
    typedef struct packed {
        logic             de;
        logic             vsync;
        logic             hsync;
        logic [RGB_W-1:0] rgb;
    } video_in_t;

    localparam tmds_symbol_t CTRL_TOKEN_00 = 10'b1101010100;
    localparam tmds_symbol_t CTRL_TOKEN_01 = 10'b0010101011;
    localparam tmds_symbol_t CTRL_TOKEN_10 = 10'b0101010100;
    localparam tmds_symbol_t CTRL_TOKEN_11 = 10'b1010101011;

    // Population count of one data byte
    function automatic logic [N1_W-1:0] count_ones8(input logic [DATA_W-1:0] v);
        logic [N1_W-1:0] s;
        s = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            s = s + N1_W'(v[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: stage 1 transition minimisation, stage 2 DC balance / control tokens.
module tmds_channel_encoder
    import tmds_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    input  logic              de,
    input  logic              c0,
    input  logic              c1,
    output tmds_symbol_t      symbol
);

    localparam tmds_disparity_t ZERO  = tmds_disparity_t'(0);
    localparam tmds_disparity_t TWO   = tmds_disparity_t'(2);
    localparam tmds_disparity_t WORD8 = tmds_disparity_t'(DATA_W);

    logic [N1_W-1:0]   n1d_c;
    logic              use_xnor_c;
    logic [DATA_W:0]   q_m_c;

    logic [DATA_W:0]   q_m_q;
    logic [N1_W-1:0]   n1_q;
    logic              de_q;
    logic [1:0]        ctrl_q;

    tmds_disparity_t   cnt_q;
    tmds_disparity_t   cnt_c;
    tmds_disparity_t   n1_s;
    tmds_disparity_t   n0_s;
    tmds_disparity_t   diff_s;
    tmds_symbol_t      sym_c;
    logic              q8;
    logic [DATA_W-1:0] q_lo;

    // Stage 1 combinational: choose XOR or XNOR chain to minimise transitions
    always_comb begin
        n1d_c      = count_ones8(d);
        use_xnor_c = (n1d_c > N1_W'(4)) || ((n1d_c == N1_W'(4)) && !d[0]);
        q_m_c      = '0;
        q_m_c[0]   = d[0];
        for (int i = 1; i < int'(DATA_W); i++) begin
            q_m_c[i] = use_xnor_c ? ~(q_m_c[i-1] ^ d[i]) : (q_m_c[i-1] ^ d[i]);
        end
        q_m_c[DATA_W] = ~use_xnor_c;
    end

    // Stage 1 register: q_m, its ones count and the aligned de/ctrl
    always_ff @(posedge clock) begin
        if (reset) begin
            q_m_q  <= '0;
            n1_q   <= '0;
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
        end else begin
            q_m_q  <= q_m_c;
            n1_q   <= count_ones8(q_m_c[DATA_W-1:0]);
            de_q   <= de;
            ctrl_q <= {c1, c0};
        end
    end

    // Stage 2 combinational: DC balancing against the running disparity
    always_comb begin
        sym_c  = CTRL_TOKEN_00;
        cnt_c  = cnt_q;
        q8     = q_m_q[DATA_W];
        q_lo   = q_m_q[DATA_W-1:0];
        n1_s   = tmds_disparity_t'({1'b0, n1_q});
        n0_s   = WORD8 - n1_s;
        diff_s = n1_s - n0_s;
        if (!de_q) begin
            case (ctrl_q)
                2'b00: sym_c = CTRL_TOKEN_00;
                2'b01: sym_c = CTRL_TOKEN_01;
                2'b10: sym_c = CTRL_TOKEN_10;
                2'b11: sym_c = CTRL_TOKEN_11;
                default: sym_c = CTRL_TOKEN_00;
            endcase
            cnt_c = ZERO;
        end else if ((cnt_q == ZERO) || (n1_s == n0_s)) begin
            sym_c = {~q8, q8, (q8 ? q_lo : ~q_lo)};
            cnt_c = q8 ? (cnt_q + diff_s) : (cnt_q - diff_s);
        end else if (((cnt_q > ZERO) && (n1_s > n0_s)) ||
                     ((cnt_q < ZERO) && (n0_s > n1_s))) begin
            sym_c = {1'b1, q8, ~q_lo};
            cnt_c = cnt_q - diff_s + (q8 ? TWO : ZERO);
        end else begin
            sym_c = {1'b0, q8, q_lo};
            cnt_c = cnt_q + diff_s - (q8 ? ZERO : TWO);
        end
    end

    // Stage 2 register: output symbol and running disparity
    always_ff @(posedge clock) begin
        if (reset) begin
            symbol <= CTRL_TOKEN_00;
            cnt_q  <= ZERO;
        end else begin
            symbol <= sym_c;
            cnt_q  <= cnt_c;
        end
    end

endmodule

// File: rtl/tmds_video_encoder.sv
// DVI TMDS encoder top: splits RGB into three lanes, applies optional sync inversion.
// Build option: define TMDS_INPUT_REG_EN to add an input register stage (latency 3 instead of 2).
module tmds_video_encoder
    import tmds_pkg::*;
#(
    parameter bit HSYNC_INVERT = 1'b0,
    parameter bit VSYNC_INVERT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [RGB_W-1:0] video_data,
    input  logic             video_de,
    input  logic             video_hsync,
    input  logic             video_vsync,
    output tmds_symbol_t     tmds_ch0,
    output tmds_symbol_t     tmds_ch1,
    output tmds_symbol_t     tmds_ch2
);

    video_in_t raw_c;
    video_in_t enc_in;

    // Bundle the inputs; sync polarity is fixed here so the register resets to token 00
    always_comb begin
        raw_c.de    = video_de;
        raw_c.hsync = video_hsync ^ HSYNC_INVERT;
        raw_c.vsync = video_vsync ^ VSYNC_INVERT;
        raw_c.rgb   = video_data;
    end

`ifdef TMDS_INPUT_REG_EN
    video_in_t in_q;

    // Optional input capture stage to relax timing from the pattern generator
    always_ff @(posedge clock) begin
        if (reset) begin
            in_q <= '0;
        end else begin
            in_q <= raw_c;
        end
    end

    assign enc_in = in_q;
`else
    assign enc_in = raw_c;
`endif

    tmds_channel_encoder u_ch0 (
        .clock  (clock),
        .reset  (reset),
        .d      (enc_in.rgb[7:0]),
        .de     (enc_in.de),
        .c0     (enc_in.hsync),
        .c1     (enc_in.vsync),
        .symbol (tmds_ch0)
    );

    tmds_channel_encoder u_ch1 (
        .clock  (clock),
        .reset  (reset),
        .d      (enc_in.rgb[15:8]),
        .de     (enc_in.de),
        .c0     (1'b0),
        .c1     (1'b0),
        .symbol (tmds_ch1)
    );

    tmds_channel_encoder u_ch2 (
        .clock  (clock),
        .reset  (reset),
        .d      (enc_in.rgb[23:16]),
        .de     (enc_in.de),
        .c0     (1'b0),
        .c1     (1'b0),
        .symbol (tmds_ch2)
    );

endmodule

// File: tb/tb_tmds_video_encoder.sv
// Testbench for tmds_video_encoder: directed cases plus random frames against a reference model.
module tb_tmds_video_encoder;

`ifdef TMDS_INPUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam bit HINV_I = 1'b1;
    localparam bit VINV_I = 1'b0;
    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;

    logic        clock;
    logic        reset;
    logic [23:0] video_data;
    logic        video_de;
    logic        video_hsync;
    logic        video_vsync;
    logic [9:0]  ch0, ch1, ch2;
    logic [9:0]  ich0, ich1, ich2;

    tmds_video_encoder dut (
        .clock       (clock),
        .reset       (reset),
        .video_data  (video_data),
        .video_de    (video_de),
        .video_hsync (video_hsync),
        .video_vsync (video_vsync),
        .tmds_ch0    (ch0),
        .tmds_ch1    (ch1),
        .tmds_ch2    (ch2)
    );

    tmds_video_encoder #(.HSYNC_INVERT(HINV_I), .VSYNC_INVERT(VINV_I)) dut_inv (
        .clock       (clock),
        .reset       (reset),
        .video_data  (video_data),
        .video_de    (video_de),
        .video_hsync (video_hsync),
        .video_vsync (video_vsync),
        .tmds_ch0    (ich0),
        .tmds_ch1    (ich1),
        .tmds_ch2    (ich2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model record of one sampled input, with control bits for both polarities
    typedef struct packed {
        logic        de;
        logic        c0n;
        logic        c1n;
        logic        c0i;
        logic        c1i;
        logic [23:0] d;
    } rec_t;

    rec_t       pipe [LAT-1];
    int         mcnt [3];
    int         obs  [3];
    logic [9:0] exp_n [3];
    logic [9:0] exp_i0;
    int         checks   = 0;
    int         failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d (0x%h) expected=%0d (0x%h) t=%0t",
                     tag, $signed(got), got, $signed(want), want, $time);
        end
    endtask

    function automatic int ones(input logic [9:0] v);
        int s = 0;
        for (int i = 0; i < 10; i++) s += int'(v[i]);
        return s;
    endfunction

    function automatic logic [9:0] ctrl_tok(input logic c1, input logic c0);
        case ({c1, c0})
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Reference TMDS data encoding; new disparity = old + (ones - zeros) of the emitted symbol
    function automatic logic [9:0] tmds_ref(input logic [7:0] d, input int cnt_in, output int cnt_out);
        logic [8:0] qm;
        logic [9:0] sym;
        int n1d, n1, n0;
        bit xn;
        n1d = ones({2'b00, d});
        xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        n1 = ones({2'b00, qm[7:0]});
        n0 = 8 - n1;
        if (cnt_in == 0 || n1 == n0)
            sym = qm[8] ? {2'b01, qm[7:0]} : {2'b10, ~qm[7:0]};
        else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1))
            sym = {1'b1, qm[8], ~qm[7:0]};
        else
            sym = {1'b0, qm[8], qm[7:0]};
        cnt_out = cnt_in + 2 * ones(sym) - 10;
        return sym;
    endfunction

    // Drive one clock of input, advance the model and scoreboard both DUTs
    task automatic step(input logic [23:0] d, input bit de, input bit hs, input bit vs, input bit rst);
        rec_t r;
        rec_t nr;
        int nc;
        logic [9:0] got [3];
        video_data  = d;
        video_de    = de;
        video_hsync = hs;
        video_vsync = vs;
        reset       = rst;
        @(posedge clock);
        #1;
        nr.de  = de;
        nr.c0n = hs;
        nr.c1n = vs;
        nr.c0i = hs ^ HINV_I;
        nr.c1i = vs ^ VINV_I;
        nr.d   = d;
        if (rst) begin
            r = '0;
            for (int k = 0; k < LAT - 1; k++) pipe[k] = '0;
        end else begin
            r = pipe[LAT-2];
            for (int k = LAT - 2; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = nr;
        end
        if (r.de) begin
            for (int c = 0; c < 3; c++) begin
                exp_n[c] = tmds_ref(r.d[8*c +: 8], mcnt[c], nc);
                mcnt[c]  = nc;
            end
            exp_i0 = exp_n[0];
        end else begin
            exp_n[0] = ctrl_tok(r.c1n, r.c0n);
            exp_n[1] = TOK00;
            exp_n[2] = TOK00;
            exp_i0   = ctrl_tok(r.c1i, r.c0i);
            for (int c = 0; c < 3; c++) mcnt[c] = 0;
        end
        check_eq("sb_ch0",  32'(ch0),  32'(exp_n[0]));
        check_eq("sb_ch1",  32'(ch1),  32'(exp_n[1]));
        check_eq("sb_ch2",  32'(ch2),  32'(exp_n[2]));
        check_eq("sb_ich0", 32'(ich0), 32'(exp_i0));
        check_eq("sb_ich1", 32'(ich1), 32'(exp_n[1]));
        check_eq("sb_ich2", 32'(ich2), 32'(exp_n[2]));
        got[0] = ch0;
        got[1] = ch1;
        got[2] = ch2;
        for (int c = 0; c < 3; c++) obs[c] = r.de ? obs[c] + 2 * ones(got[c]) - 10 : 0;
    endtask

    function automatic logic [23:0] rand_px();
        int sel;
        logic [7:0] b;
        sel = $urandom_range(0, 7);
        b   = 8'($urandom);
        if (sel == 0)      return 24'h000000;
        else if (sel == 1) return 24'hFFFFFF;
        else if (sel == 2) return {b, b, b};
        else               return 24'($urandom);
    endfunction

    task automatic blank(input int n, input bit hs, input bit vs);
        for (int i = 0; i < n; i++) step(24'($urandom), 1'b0, hs, vs, 1'b0);
    endtask

    initial begin
        logic [23:0] first_px;
        logic [9:0]  want;
        int          dummy;
        video_data  = '0;
        video_de    = 1'b0;
        video_hsync = 1'b0;
        video_vsync = 1'b0;
        reset       = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mcnt[c] = 0;
            obs[c]  = 0;
        end

        // Reset held 3 clocks, then idle
        for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_ch0", 32'(ch0), 32'(TOK00));
        check_eq("rst_ch1", 32'(ch1), 32'(TOK00));
        check_eq("rst_ch2", 32'(ch2), 32'(TOK00));
        for (int i = 0; i < 2; i++) begin
            step('0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_eq("idle_ch0", 32'(ch0), 32'(TOK00));
        end

        // hsync-only blanking, both polarities
        for (int i = 0; i < LAT + 1; i++) step(24'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("hs_ch0",     32'(ch0),  32'(TOK01));
        check_eq("hs_ch1",     32'(ch1),  32'(TOK00));
        check_eq("hs_ch2",     32'(ch2),  32'(TOK00));
        check_eq("hs_inv_ch0", 32'(ich0), 32'(TOK00));

        // Two black pixels after blanking
        blank(4, 1'b0, 1'b0);
        step(24'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
        step(24'h000000, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < LAT - 2; i++) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("blk1_ch0", 32'(ch0), 32'(10'b0100000000));
        check_eq("blk1_ch1", 32'(ch1), 32'(10'b0100000000));
        check_eq("blk1_ch2", 32'(ch2), 32'(10'b0100000000));
        check_eq("blk1_disp", 32'(obs[1]), 32'(-8));
        step('0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("blk2_ch0", 32'(ch0), 32'(10'b1111111111));
        check_eq("blk2_ch2", 32'(ch2), 32'(10'b1111111111));
        check_eq("blk2_disp", 32'(obs[0]), 32'(2));

        // One white pixel then blanking
        blank(4, 1'b0, 1'b0);
        step(24'hFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < LAT - 1; i++) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("wht_ch0", 32'(ch0), 32'(10'b1000000000));
        check_eq("wht_ch1", 32'(ch1), 32'(10'b1000000000));
        check_eq("wht_ch2", 32'(ch2), 32'(10'b1000000000));
        check_eq("wht_disp", 32'(obs[2]), 32'(-8));
        step('0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("wht_blank_ch0", 32'(ch0), 32'(TOK00));
        check_eq("wht_blank_disp", 32'(obs[0]), 32'(0));

        // Random frames: vertical blank, then lines with hsync pulses and 1280 active pixels
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 30; i++) step(24'($urandom), 1'b0, 1'($urandom), 1'b1, 1'b0);
            for (int ln = 0; ln < 2; ln++) begin
                blank(8, 1'b0, 1'b0);
                blank(12, 1'b1, 1'b0);
                blank(8, 1'b0, 1'b0);
                for (int p = 0; p < 1280; p++) step(rand_px(), 1'b1, 1'b0, 1'b0, 1'b0);
                blank(LAT - 1, 1'b0, 1'b0);
                for (int c = 0; c < 3; c++)
                    check_eq("line_disp_ok", 32'(obs[c] >= -8 && obs[c] <= 8), 32'd1);
                blank(4, 1'b0, 1'b0);
            end
        end

        // Reset pulsed in the middle of an active line
        blank(6, 1'b0, 1'b0);
        for (int p = 0; p < 100; p++) step(rand_px(), 1'b1, 1'b0, 1'b0, 1'b0);
        step(rand_px(), 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("midrst_ch0", 32'(ch0), 32'(TOK00));
        check_eq("midrst_ch1", 32'(ch1), 32'(TOK00));
        check_eq("midrst_ch2", 32'(ch2), 32'(TOK00));
        first_px = 24'h5A3C96 ^ 24'($urandom);
        step(first_px, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < LAT - 1; i++) step(rand_px(), 1'b1, 1'b0, 1'b0, 1'b0);
        want = tmds_ref(first_px[7:0], 0, dummy);
        check_eq("post_rst_ch0", 32'(ch0), 32'(want));
        want = tmds_ref(first_px[23:16], 0, dummy);
        check_eq("post_rst_ch2", 32'(ch2), 32'(want));
        for (int p = 0; p < 50; p++) step(rand_px(), 1'b1, 1'b0, 1'b0, 1'b0);
        blank(LAT + 2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
